// File: rtl/tx_link_fault_resp_pkg.sv
// Shared XGMII character and fault-code constants and the link fault state encoding
// for the transmit-side link fault responder.
package tx_link_fault_resp_pkg;

    localparam logic [7:0] XGMII_IDLE  = 8'h07;
    localparam logic [7:0] XGMII_START = 8'hFB;
    localparam logic [7:0] XGMII_TERM  = 8'hFD;
    localparam logic [7:0] XGMII_SEQ   = 8'h9C;

    localparam logic [1:0] LOCAL_FAULT  = 2'b10;
    localparam logic [1:0] REMOTE_FAULT = 2'b01;

    typedef enum logic [1:0] {
        ST_OK     = 2'b00,
        ST_REMOTE = 2'b01,
        ST_LOCAL  = 2'b10
    } fault_state_e;

    // One 32-bit column of the Remote Fault ordered set, lane 0 in the low byte.
    function automatic logic [31:0] remote_fault_column();
        return {8'h02, 8'h00, 8'h00, XGMII_SEQ};
    endfunction

endpackage

// File: rtl/tx_link_fault_resp_hold_timer.sv
// link_fault_hold_timer: fault hold counter with reload on a pulse and an expiry flag
// raised on the cycle the count reaches zero.
module link_fault_hold_timer #(
    parameter int HOLD_CYCLES = 128
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic load_i,
    output logic expire_o
);

    localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = CW'(HOLD_CYCLES - 1);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    // A reload in the same cycle always wins over expiry.
    assign expire_o = !load_i && (cnt_q <= CW'(1));

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/tx_link_fault_resp.sv
// Transmit link fault responder: replaces MAC traffic with Remote Fault or Idle while a
// fault is held, switching only between frames. Optional stats via TX_LINK_FAULT_STATS_EN.
module tx_link_fault_resp
    import tx_link_fault_resp_pkg::*;
#(
    parameter int HOLD_CYCLES = 128,
    parameter int DW          = 64
) (
    input  logic            txclk_2x,
    input  logic            reset_n,
    input  logic [1:0]      link_fault,
    input  logic [DW-1:0]   mac_txd,
    input  logic [DW/8-1:0] mac_txc,
    output logic [DW-1:0]   txd,
    output logic [DW/8-1:0] txc,
    output logic            tx_enable,
    output logic [1:0]      fault_state
`ifdef TX_LINK_FAULT_STATS_EN
    ,
    output logic [15:0]     local_cnt,
    output logic [15:0]     remote_cnt
`endif
);

    localparam int NL = DW / 8;
    localparam int HL = NL / 2;

    fault_state_e    state_q, state_d, pend_q, pend_d;
    logic            in_frame_q, in_frame_d;
    logic [DW-1:0]   txd_q, txd_d;
    logic [NL-1:0]   txc_q, txc_d;
    logic            tx_enable_q;
    logic            start_lo, start_hi, has_term;
    logic            pulse_local, pulse_remote, load, expire;

    always_comb begin
        has_term = 1'b0;
        for (int i = 0; i < NL; i++) begin
            if (mac_txc[i] && mac_txd[8*i +: 8] == XGMII_TERM) has_term = 1'b1;
        end
        start_lo = mac_txc[0]  && (mac_txd[7:0] == XGMII_START);
        start_hi = mac_txc[HL] && (mac_txd[8*HL +: 8] == XGMII_START);
    end

    // A Start in the upper column follows any Terminate in the lower one.
    always_comb begin
        in_frame_d = in_frame_q;
        if (start_hi)      in_frame_d = 1'b1;
        else if (has_term) in_frame_d = 1'b0;
        else if (start_lo) in_frame_d = 1'b1;
    end

    assign pulse_local  = link_fault[1];
    assign pulse_remote = (link_fault == REMOTE_FAULT);
    assign load         = pulse_local || (pulse_remote && pend_q != ST_LOCAL);

    link_fault_hold_timer #(
        .HOLD_CYCLES(HOLD_CYCLES)
    ) u_hold (
        .clk_i   (txclk_2x),
        .rst_ni  (reset_n),
        .load_i  (load),
        .expire_o(expire)
    );

    always_comb begin
        pend_d = pend_q;
        if (pulse_local)       pend_d = ST_LOCAL;
        else if (load)         pend_d = ST_REMOTE;
        else if (expire)       pend_d = ST_OK;
    end

    // State changes only between frames, so a frame is never cut or half-forwarded.
    assign state_d = (!in_frame_q && !start_lo && !start_hi) ? pend_q : state_q;

    always_comb begin
        txd_d = {NL{XGMII_IDLE}};
        txc_d = '1;
        case (state_d)
            ST_OK: begin
                txd_d = mac_txd;
                txc_d = mac_txc;
            end
            ST_LOCAL: begin
                txd_d = {(DW/32){remote_fault_column()}};
                txc_d = {(DW/32){4'b0001}};
            end
            default: ;
        endcase
    end

    always_ff @(posedge txclk_2x) begin
        if (!reset_n) begin
            state_q     <= ST_OK;
            pend_q      <= ST_OK;
            in_frame_q  <= 1'b0;
            txd_q       <= {NL{XGMII_IDLE}};
            txc_q       <= '1;
            tx_enable_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pend_q      <= pend_d;
            in_frame_q  <= in_frame_d;
            txd_q       <= txd_d;
            txc_q       <= txc_d;
            tx_enable_q <= (state_q == ST_OK) && (pend_q == ST_OK);
        end
    end

    assign txd         = txd_q;
    assign txc         = txc_q;
    assign tx_enable   = tx_enable_q;
    assign fault_state = state_q;

`ifdef TX_LINK_FAULT_STATS_EN
    logic [15:0] local_cnt_q, remote_cnt_q;

    always_ff @(posedge txclk_2x) begin
        if (!reset_n) begin
            local_cnt_q  <= '0;
            remote_cnt_q <= '0;
        end else begin
            if (state_d == ST_LOCAL && state_q != ST_LOCAL && local_cnt_q != 16'hFFFF)
                local_cnt_q <= local_cnt_q + 16'd1;
            if (state_d == ST_REMOTE && state_q != ST_REMOTE && remote_cnt_q != 16'hFFFF)
                remote_cnt_q <= remote_cnt_q + 16'd1;
        end
    end

    assign local_cnt  = local_cnt_q;
    assign remote_cnt = remote_cnt_q;
`endif

endmodule

// File: doc/tx_link_fault_resp.md
TX_LINK_FAULT_RESP -- requirements
Module: tx_link_fault_resp

Interface
REQ-001 SHALL have parameter HOLD_CYCLES, default 128: cycles a fault status is held after its last link_fault pulse.
REQ-002 SHALL have parameter DW, default 64: XGMII data width, two 32-bit columns.
REQ-003 SHALL have port txclk_2x  input  1  transmit clock; one clock; every register updates on its rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port link_fault  input  2  fault pulse from the receive side: 2'b10 local, 2'b01 remote, 2'b00 none, 2'b11 treated as local.
REQ-006 SHALL have port mac_txd  input  64  XGMII data from the MAC transmit engine.
REQ-007 SHALL have port mac_txc  input  8  XGMII control from the MAC, one bit per byte.
REQ-008 SHALL have port txd  output  64  XGMII data to the PHY.
REQ-009 SHALL have port txc  output  8  XGMII control to the PHY.
REQ-010 SHALL have port tx_enable  output  1  high when the MAC is allowed to start a frame.
REQ-011 SHALL have port fault_state  output  2  current state encoding: 00 OK, 01 REMOTE, 10 LOCAL.

Function
REQ-012 SHALL implement states OK, LOCAL, REMOTE, plus a frame-tracking flag in_frame.
- in_frame sets on a Start char 0xFB with txc=1 in lane 0 or lane 4.
- in_frame clears on a Terminate char 0xFD with txc=1 in any lane.
REQ-013 A local pulse SHALL latch pend=LOCAL and reload the hold counter to HOLD_CYCLES-1; a remote pulse SHALL do the same with pend=REMOTE, unless pend is already LOCAL.
REQ-014 When a pulse and hold-counter expiry occur in the same cycle, the pulse SHALL take precedence.
REQ-015 The hold counter SHALL decrement each cycle without a pulse; on reaching 0, pend SHALL become OK; the counter SHALL NOT wrap below 0.
REQ-016 The state SHALL load pend only in a cycle where in_frame=0 and the current word contains no Start; otherwise the change is deferred to the first such cycle.
REQ-017 OK: txd/txc SHALL equal mac_txd/mac_txc, registered, with 1-cycle latency.
REQ-018 LOCAL: both columns SHALL carry the Remote Fault ordered set.
- Lanes 0..3 = 0x9C, 0x00, 0x00, 0x02.
- txc nibble = 4'b0001.
REQ-019 REMOTE: every lane SHALL carry Idle 0x07 with txc=8'hFF.
REQ-020 tx_enable SHALL equal (state==OK && pend==OK), registered; the MAC waits for tx_enable before asserting Start.
REQ-021 In LOCAL and REMOTE states, any Start arriving from the MAC SHALL be discarded; the block SHALL NOT forward a partial frame.
REQ-022 fault_state SHALL be updated in the same cycle as the state register.

Reset
REQ-023 While reset_n=0 at a clock edge, the block SHALL load:
- state=OK, pend=OK, hold counter=0, in_frame=0;
- txd={8{0x07}}, txc=8'hFF, tx_enable=0, fault_state=00.
REQ-024 A reset asserted mid-frame SHALL abandon the frame; the first cycle after release SHALL output Idle.

Configuration
REQ-025 With TX_LINK_FAULT_STATS_EN defined, the block SHALL add outputs local_cnt[15:0] and remote_cnt[15:0].
- Each increments on entry to LOCAL or REMOTE respectively.
- Each saturates at 16'hFFFF.
- Both clear on reset.
REQ-026 Without TX_LINK_FAULT_STATS_EN, those ports and counters SHALL NOT exist, and all other behaviour is identical.

Structure
REQ-027 A shared package SHALL hold:
- XGMII character constants: IDLE 0x07, START 0xFB, TERM 0xFD, SEQ 0x9C;
- fault code constants LOCAL_FAULT=2'b10 and REMOTE_FAULT=2'b01;
- the state enumeration.
REQ-028 The hold timer (counter, reload, expiry flag) SHALL be one sub-module, link_fault_hold_timer; all else stays in tx_link_fault_resp.

Verification
REQ-029 Idle link: reset, no pulses, MAC sends a 64-byte frame -> txd/txc equal the MAC input delayed 1 cycle; tx_enable=1.
REQ-030 Local fault: single 2'b10 pulse while idle -> within 2 cycles txd=64'h0200009C_0200009C and txc=8'h11; after 128 pulse-free cycles, Idle/passthrough returns and tx_enable=1.
REQ-031 Deferral: 2'b01 pulse mid-frame -> frame completes unmodified through Terminate; next cycle txd=all 0x07, txc=8'hFF; fault_state=01.
REQ-032 Precedence: remote pulse, then local pulse 10 cycles later -> state LOCAL; a further remote pulse leaves the state LOCAL.
REQ-033 Refresh: local pulse every 100 cycles for 1000 cycles -> state stays LOCAL throughout; leaves 128 cycles after the last pulse.
REQ-034 Reset mid-fault: reset_n low 1 cycle while in LOCAL -> next cycle Idle, fault_state=00, stats counters 0 when TX_LINK_FAULT_STATS_EN is defined.
